// File: rtl/snes_source_arbiter.sv
// Picks the source (keyboard, IR, button board) that drives the SNES pad and snapshots its word per console latch.
// Latency: owner one clock after activity; snap_data/snap_valid on the 3rd rising clock after load_async rises.
// No backpressure: sources are sampled every cycle and snap_data is held until the next latch.
module snes_source_arbiter #(
   parameter int HOLD_CYCLES = 1000000,
   parameter int CNT_W       = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] dip,
   input  logic [7:0] kb_buttons,
   input  logic       kb_valid,
   input  logic [7:0] ir_buttons,
   input  logic       ir_valid,
   input  logic [7:0] btn_buttons,
   input  logic       load_async,
   output logic [7:0] snap_data,
   output logic       snap_valid,
   output logic [1:0] owner
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWNED  = 2'd1,
      ST_FORCED = 2'd2
   } state_t;

   localparam logic [1:0] SRC_NONE = 2'b00;
   localparam logic [1:0] SRC_KB   = 2'b01;
   localparam logic [1:0] SRC_IR   = 2'b10;
   localparam logic [1:0] SRC_BTN  = 2'b11;

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t           state_q;
   logic [1:0]       owner_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       dip_q;
   logic [1:0]       dip_prev_q;
   logic [7:0]       kb_word_q;
   logic [7:0]       ir_word_q;
   logic [7:0]       btn_word_q;
   logic             s1_q;
   logic             s2_q;
   logic             s3_q;
   logic [1:0]       prime_q;
   logic             arm_q;
   logic [7:0]       snap_data_q;
   logic             snap_valid_q;

   logic             kb_act;
   logic             ir_act;
   logic             btn_act;
   logic             owner_act;
   logic             dip_chg;
   logic             latch_edge;
   logic [7:0]       sel_word;

   // Activity decode, owner-activity select and the word of the current owner.
   always_comb begin
      kb_act     = kb_valid & (|kb_buttons);
      ir_act     = ir_valid & (|ir_buttons);
      btn_act    = |btn_buttons;
      dip_chg    = (dip_q != dip_prev_q);
      latch_edge = arm_q & s2_q & ~s3_q;
      owner_act  = 1'b0;
      sel_word   = 8'h00;
      case (owner_q)
         SRC_KB:  begin owner_act = kb_act;  sel_word = kb_word_q;  end
         SRC_IR:  begin owner_act = ir_act;  sel_word = ir_word_q;  end
         SRC_BTN: begin owner_act = btn_act; sel_word = btn_word_q; end
         default: begin owner_act = 1'b0;    sel_word = 8'h00;      end
      endcase
   end

   // Source word registers and the registered DIP mode (plus its previous value for change detection).
   always_ff @(posedge clock) begin
      if (reset) begin
         kb_word_q  <= 8'h00;
         ir_word_q  <= 8'h00;
         btn_word_q <= 8'h00;
         dip_q      <= 2'b00;
         dip_prev_q <= 2'b00;
      end else begin
         if (kb_valid) kb_word_q <= kb_buttons;
         if (ir_valid) ir_word_q <= ir_buttons;
         btn_word_q <= btn_buttons;
         dip_q      <= dip;
         dip_prev_q <= dip_q;
      end
   end

   // Ownership FSM: a mode change parks it in IDLE for one cycle, forced modes pin the owner,
   // auto mode grabs the highest-priority active source and releases it after the idle hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= SRC_NONE;
         cnt_q   <= '0;
      end else if (dip_chg) begin
         state_q <= ST_IDLE;
         owner_q <= SRC_NONE;
         cnt_q   <= '0;
      end else if (dip_q != 2'b00) begin
         state_q <= ST_FORCED;
         owner_q <= dip_q;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (btn_act | kb_act | ir_act) begin
                  state_q <= ST_OWNED;
                  cnt_q   <= RELOAD;
                  if (btn_act)     owner_q <= SRC_BTN;
                  else if (kb_act) owner_q <= SRC_KB;
                  else             owner_q <= SRC_IR;
               end
            end
            ST_OWNED: begin
               // Owner activity on the expiry cycle still reloads, so it never loses ownership.
               if (owner_act) begin
                  cnt_q <= RELOAD;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  state_q <= ST_IDLE;
                  owner_q <= SRC_NONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               owner_q <= SRC_NONE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Latch synchroniser and capture; arm_q blocks a capture until the synchronised latch has been
   // seen low after reset, so a latch held high across reset does not fire.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
         prime_q      <= 2'd0;
         arm_q        <= 1'b0;
         snap_data_q  <= 8'h00;
         snap_valid_q <= 1'b0;
      end else begin
         s1_q <= load_async;
         s2_q <= s1_q;
         s3_q <= s2_q;
         if (prime_q != 2'd2) prime_q <= prime_q + 2'd1;
         if ((prime_q == 2'd2) && !s2_q) arm_q <= 1'b1;
         if (latch_edge) snap_data_q <= sel_word;
         snap_valid_q <= latch_edge;
      end
   end

   assign snap_data  = snap_data_q;
   assign snap_valid = snap_valid_q;
   assign owner      = owner_q;

endmodule

// File: tb/tb_snes_source_arbiter.sv
// Directed bench for snes_source_arbiter with a 16-cycle hold.
// Inputs are driven 1 ns after each rising edge and outputs sampled at the same point.
// Covers reset, auto ownership and hold, priority, reload at expiry, forced mode and reset mid-latch.
module tb_snes_source_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] dip;
   logic [7:0] kb_buttons;
   logic       kb_valid;
   logic [7:0] ir_buttons;
   logic       ir_valid;
   logic [7:0] btn_buttons;
   logic       load_async;
   logic [7:0] snap_data;
   logic       snap_valid;
   logic [1:0] owner;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses;
   int bad;

   snes_source_arbiter #(.HOLD_CYCLES(16), .CNT_W(5)) dut (
      .clock       (clock),
      .reset       (reset),
      .dip         (dip),
      .kb_buttons  (kb_buttons),
      .kb_valid    (kb_valid),
      .ir_buttons  (ir_buttons),
      .ir_valid    (ir_valid),
      .btn_buttons (btn_buttons),
      .load_async  (load_async),
      .snap_data   (snap_data),
      .snap_valid  (snap_valid),
      .owner       (owner)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) for ownership to drop back to none.
   task automatic wait_idle(input string tag);
      for (int i = 0; i < 40 && owner != 2'b00; i++) tick();
      check(tag, owner, 0);
   endtask

   task automatic kb_pulse(input logic [7:0] w);
      kb_valid = 1'b1; kb_buttons = w;
      tick();
      kb_valid = 1'b0; kb_buttons = 8'h00;
   endtask

   initial begin
      reset = 1'b1; dip = 2'b00; kb_buttons = 8'h00; kb_valid = 1'b0;
      ir_buttons = 8'h00; ir_valid = 1'b0; btn_buttons = 8'h00; load_async = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_owner", owner, 0);
      check("rst_snap_data", snap_data, 0);
      check("rst_snap_valid", snap_valid, 0);
      reset = 1'b0;
      repeat (3) tick();
      check("idle_owner", owner, 0);

      // Keyboard acquires, then a latch captures its word on the 3rd edge
      kb_pulse(8'h41);
      check("kb_acquire", owner, 1);
      load_async = 1'b1;
      tick(); check("latch_e1_valid", snap_valid, 0);
      tick(); check("latch_e2_valid", snap_valid, 0);
      check("latch_e2_data", snap_data, 8'h00);
      tick(); check("latch_e3_valid", snap_valid, 1);
      check("latch_e3_data", snap_data, 8'h41);
      tick(); check("latch_e4_valid", snap_valid, 0);
      check("latch_hold_data", snap_data, 8'h41);
      pulses = 0;
      repeat (5) begin tick(); if (snap_valid) pulses++; end
      check("held_latch_single", pulses, 0);
      load_async = 1'b0;

      // Hold: IR activity ignored while keyboard owns; release after 16 idle cycles
      kb_pulse(8'h41);
      ir_valid = 1'b1; ir_buttons = 8'h0F;
      bad = 0;
      for (int i = 0; i < 15; i++) begin tick(); if (owner != 2'b01) bad++; end
      check("hold_ignores_ir", bad, 0);
      tick(); check("hold_release", owner, 0);
      tick(); check("ir_acquire", owner, 2);
      ir_valid = 1'b0; ir_buttons = 8'h00;

      // Simultaneous acquisition: buttons win
      wait_idle("ir_release");
      btn_buttons = 8'h01;
      kb_valid = 1'b1; kb_buttons = 8'h02;
      ir_valid = 1'b1; ir_buttons = 8'h04;
      tick();
      kb_valid = 1'b0; kb_buttons = 8'h00; ir_valid = 1'b0; ir_buttons = 8'h00;
      check("prio_btn_owner", owner, 3);
      load_async = 1'b1;
      repeat (3) tick();
      check("prio_snap_valid", snap_valid, 1);
      check("prio_snap_data", snap_data, 8'h01);
      load_async = 1'b0; btn_buttons = 8'h00;
      tick();

      // Reload exactly on the counter-zero cycle
      wait_idle("btn_release");
      kb_pulse(8'h55);
      check("kb_reacquire", owner, 1);
      repeat (15) tick();
      kb_pulse(8'h55);
      check("reload_at_zero", owner, 1);
      bad = 0;
      for (int i = 0; i < 15; i++) begin tick(); if (owner != 2'b01) bad++; end
      check("reload_full_hold", bad, 0);
      tick(); check("release_after_reload", owner, 0);

      // Forced IR mode
      kb_pulse(8'h33);
      check("kb_own_before_force", owner, 1);
      dip = 2'b10;
      tick(); check("dip_reg_delay", owner, 1);
      tick(); check("dip_change_idle", owner, 0);
      tick(); check("forced_ir", owner, 2);
      kb_pulse(8'h77);
      check("forced_ignores_kb", owner, 2);
      load_async = 1'b1;
      repeat (3) tick();
      check("forced_snap_valid", snap_valid, 1);
      check("forced_snap_data", snap_data, 8'h04);
      load_async = 1'b0;
      repeat (100) tick();
      check("forced_no_release", owner, 2);

      // Reset while a latch is in the sync chain
      dip = 2'b11;
      repeat (3) tick();
      check("forced_btn", owner, 3);
      load_async = 1'b1;
      tick(); tick();
      reset = 1'b1;
      tick();
      check("midrst_owner", owner, 0);
      check("midrst_snap_valid", snap_valid, 0);
      check("midrst_snap_data", snap_data, 0);
      tick();
      check("midrst_snap_valid2", snap_valid, 0);
      dip = 2'b00;
      reset = 1'b0;
      pulses = 0;
      repeat (10) begin tick(); if (snap_valid) pulses++; end
      check("held_across_reset", pulses, 0);
      kb_pulse(8'h5A);
      check("post_rst_kb", owner, 1);
      load_async = 1'b0;
      repeat (4) tick();
      load_async = 1'b1;
      repeat (3) tick();
      check("rearm_snap_valid", snap_valid, 1);
      check("rearm_snap_data", snap_data, 8'h5A);
      load_async = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
